// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory access size codes and the MEM-stage state type.
package mips_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

  // The illegal size code 2'b11 is handled like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = addr_lo[0];
      default:  mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a read word and zero- or sign-extends it.
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);
  import mips_pkg::*;

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[{addr_lo, 3'b000} +: 8];
    half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: result = {{24{sign_ext & byte_val[7]}}, byte_val};
      MEM_HALF: result = {{16{sign_ext & half_val[15]}}, half_val};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores over a req/ack data port, stalls upstream while
// an access is outstanding and registers the result into the MEM/WB boundary.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_regWriteEn,
  input  logic [4:0]  mem_regWriteAddr,
  input  logic [31:0] mem_regWriteData,
  input  logic        mem_memRead,
  input  logic        mem_memWrite,
  input  logic [1:0]  mem_memSize,
  input  logic        mem_memSigned,
  input  logic [31:0] mem_storeData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_regWriteEn,
  output logic [4:0]  wb_regWriteAddr,
  output logic [31:0] wb_regWriteData,
  output logic        mem_misalign,
  output logic        mem_buserr
);
  import mips_pkg::*;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             misalign_q, misalign_d;
  logic             buserr_q, buserr_d;

  logic        mem_op;
  logic        misaligned;
  logic        timeout_hit;
  logic [1:0]  a_lo;
  logic [31:0] load_result;

  assign a_lo        = mem_regWriteData[1:0];
  assign mem_op      = mem_memRead | mem_memWrite;
  assign misaligned  = is_misaligned(mem_memSize, a_lo);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !dmem_ack;

  load_align u_load_align (
    .rdata    (rdata_q),
    .addr_lo  (a_lo),
    .size     (mem_memSize),
    .sign_ext (mem_memSigned),
    .result   (load_result)
  );

  // The abort cycle already releases the stall so upstream moves on with the bus error.
  assign dmem_req  = !rst && (state_q == ST_REQ);
  assign mem_stall = !rst && (((state_q == ST_IDLE) && mem_op && !misaligned) ||
                              ((state_q == ST_REQ) && !timeout_hit));
  assign dmem_we   = dmem_req & mem_memWrite;
  assign dmem_addr = {mem_regWriteData[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = mem_storeData;
    case (mem_memSize)
      MEM_BYTE: begin
        dmem_be    = 4'b0001 << a_lo;
        dmem_wdata = {4{mem_storeData[7:0]}};
      end
      MEM_HALF: begin
        dmem_be    = a_lo[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{mem_storeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    wb_en_d    = wb_en_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    buserr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          wb_en_d   = mem_regWriteEn;
          wb_addr_d = mem_regWriteAddr;
          wb_data_d = mem_regWriteData;
        end else if (misaligned) begin
          wb_en_d    = 1'b0;
          misalign_d = 1'b1;
        end else begin
          // Bubble into writeback while the access is in flight.
          wb_en_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        wb_en_d = 1'b0;
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          buserr_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        wb_en_d   = mem_regWriteEn;
        wb_addr_d = mem_regWriteAddr;
        wb_data_d = mem_memRead ? load_result : mem_regWriteData;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  assign wb_regWriteEn   = wb_en_q;
  assign wb_regWriteAddr = wb_addr_q;
  assign wb_regWriteData = wb_data_q;
  assign mem_misalign    = misalign_q;
  assign mem_buserr      = buserr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset corner cases and random ops
// checked against a byte-addressed memory model.
module tb_mem_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_regWriteEn;
  logic [4:0]  mem_regWriteAddr;
  logic [31:0] mem_regWriteData;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [1:0]  mem_memSize;
  logic        mem_memSigned;
  logic [31:0] mem_storeData;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        wb_regWriteEn;
  logic [4:0]  wb_regWriteAddr;
  logic [31:0] wb_regWriteData;
  logic        mem_misalign;
  logic        mem_buserr;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_regWriteEn   (mem_regWriteEn),
    .mem_regWriteAddr (mem_regWriteAddr),
    .mem_regWriteData (mem_regWriteData),
    .mem_memRead      (mem_memRead),
    .mem_memWrite     (mem_memWrite),
    .mem_memSize      (mem_memSize),
    .mem_memSigned    (mem_memSigned),
    .mem_storeData    (mem_storeData),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (dmem_be),
    .dmem_wdata       (dmem_wdata),
    .dmem_ack         (dmem_ack),
    .dmem_rdata       (dmem_rdata),
    .mem_stall        (mem_stall),
    .wb_regWriteEn    (wb_regWriteEn),
    .wb_regWriteAddr  (wb_regWriteAddr),
    .wb_regWriteData  (wb_regWriteData),
    .mem_misalign     (mem_misalign),
    .mem_buserr       (mem_buserr)
  );

  typedef struct {
    logic        we_en;
    logic [4:0]  waddr;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] sdata;
    int          ack_delay;
  } op_t;

  typedef struct {
    op_t         op;
    logic        preload;
    logic [31:0] pre_word;
    logic        exp_en;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mem_model [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_regWriteEn   = 1'b0;
    mem_regWriteAddr = '0;
    mem_regWriteData = '0;
    mem_memRead      = 1'b0;
    mem_memWrite     = 1'b0;
    mem_memSize      = 2'b00;
    mem_memSigned    = 1'b0;
    mem_storeData    = '0;
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    int key = int'(a >> 2);
    return mem_model.exists(key) ? mem_model[key] : 32'h0;
  endfunction

  function automatic logic model_misaligned(input op_t op);
    int off = int'(op.addr % 4);
    if (op.size == 2'd0) return 1'b0;
    if (op.size == 2'd1) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] model_load(input op_t op);
    logic [31:0] w = mem_read(op.addr);
    int off = int'(op.addr % 4);
    logic [31:0] v;
    if (op.size == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (op.sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (op.size == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (op.sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_be(input op_t op);
    int off = int'(op.addr % 4);
    if (op.size == 2'd0) return 32'(1 << off);
    if (op.size == 2'd1) return (off >= 2) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input op_t op);
    if (op.size == 2'd0) return (op.sdata & 32'hFF) * 32'h01010101;
    if (op.size == 2'd1) return (op.sdata & 32'hFFFF) * 32'h00010001;
    return op.sdata;
  endfunction

  task automatic model_store(input op_t op);
    int key = int'(op.addr >> 2);
    int off = int'(op.addr % 4);
    logic [31:0] w = mem_read(op.addr);
    logic [31:0] mask;
    if (op.size == 2'd0) begin
      mask = 32'hFF << (8 * off);
      w = (w & ~mask) | ((op.sdata & 32'hFF) << (8 * off));
    end else if (op.size == 2'd1) begin
      mask = 32'hFFFF << (16 * (off / 2));
      w = (w & ~mask) | ((op.sdata & 32'hFFFF) << (16 * (off / 2)));
    end else begin
      w = op.sdata;
    end
    mem_model[key] = w;
  endtask

  function automatic op_t mk(input logic we_en, input logic [31:0] addr, input logic rd,
                             input logic wr, input logic [1:0] size, input logic sgn,
                             input logic [31:0] sdata, input int ack_delay);
    op_t o;
    o.we_en = we_en;
    o.waddr = 5'd9;
    o.addr = addr;
    o.rd = rd;
    o.wr = wr;
    o.size = size;
    o.sgn = sgn;
    o.sdata = sdata;
    o.ack_delay = ack_delay;
    return o;
  endfunction

  task automatic bubble();
    clear_inputs();
    tick();
    check("pulse_end_misalign", 32'(mem_misalign), 0);
    check("pulse_end_buserr", 32'(mem_buserr), 0);
  endtask

  // Presents one instruction starting just after a rising edge and follows it to retirement.
  task automatic applyStimulus(input op_t op);
    logic acked = 1'b0;
    logic aborted = 1'b0;
    int stalls = 0;
    mem_regWriteEn   = op.we_en;
    mem_regWriteAddr = op.waddr;
    mem_regWriteData = op.addr;
    mem_memRead      = op.rd;
    mem_memWrite     = op.wr;
    mem_memSize      = op.size;
    mem_memSigned    = op.sgn;
    mem_storeData    = op.sdata;
    if (!(op.rd || op.wr)) begin
      @(negedge clk);
      check("alu_stall", 32'(mem_stall), 0);
      check("alu_req", 32'(dmem_req), 0);
      tick();
      check("alu_wb_en", 32'(wb_regWriteEn), 32'(op.we_en));
      check("alu_wb_addr", 32'(wb_regWriteAddr), 32'(op.waddr));
      check("alu_wb_data", wb_regWriteData, op.addr);
    end else if (model_misaligned(op)) begin
      @(negedge clk);
      check("mis_stall", 32'(mem_stall), 0);
      check("mis_req", 32'(dmem_req), 0);
      tick();
      check("mis_pulse", 32'(mem_misalign), 1);
      check("mis_wb_en", 32'(wb_regWriteEn), 0);
      bubble();
    end else begin
      @(negedge clk);
      check("idle_req", 32'(dmem_req), 0);
      stalls += int'(mem_stall);
      tick();
      for (int c = 0; c < 20 && !acked && !aborted; c++) begin
        if (c == op.ack_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = op.rd ? mem_read(op.addr) : $urandom;
        end
        @(negedge clk);
        check("req_active", 32'(dmem_req), 1);
        check("req_addr", dmem_addr, op.addr & 32'hFFFFFFFC);
        check("req_we", 32'(dmem_we), 32'(op.wr));
        if (op.wr) begin
          check("req_be", 32'(dmem_be), model_be(op));
          check("req_wdata", dmem_wdata, model_wdata(op));
        end
        if (dmem_ack) acked = 1'b1;
        else if (c == int'(TO) - 1) aborted = 1'b1;
        check("req_stall", 32'(mem_stall), aborted ? 0 : 1);
        stalls += int'(mem_stall);
        tick();
        dmem_ack = 1'b0;
      end
      if (acked) begin
        check("stall_count", 32'(stalls), 32'(2 + op.ack_delay));
        dmem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_stall", 32'(mem_stall), 0);
        check("done_req", 32'(dmem_req), 0);
        tick();
        dmem_ack = 1'b0;
        check("done_wb_en", 32'(wb_regWriteEn), 32'(op.we_en));
        check("done_wb_addr", 32'(wb_regWriteAddr), 32'(op.waddr));
        check("done_wb_data", wb_regWriteData, op.rd ? model_load(op) : op.addr);
        check("done_buserr", 32'(mem_buserr), 0);
        if (op.wr) model_store(op);
      end else begin
        check("timeout_stall_count", 32'(stalls), 32'(TO));
        check("timeout_buserr", 32'(mem_buserr), 1);
        check("timeout_wb_en", 32'(wb_regWriteEn), 0);
        bubble();
      end
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check($sformatf("vec%0d_wb_en", idx), 32'(wb_regWriteEn), 32'(v.exp_en));
    if (v.chk_data) check($sformatf("vec%0d_wb_data", idx), wb_regWriteData, v.exp_data);
  endtask

  function automatic vec_t mkv(input op_t op, input logic preload, input logic [31:0] pre_word,
                               input logic exp_en, input logic chk_data, input logic [31:0] exp_data);
    vec_t v;
    v.op = op;
    v.preload = preload;
    v.pre_word = pre_word;
    v.exp_en = exp_en;
    v.chk_data = chk_data;
    v.exp_data = exp_data;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    op_t  rop;
    int   kind;
    int   off;

    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    clear_inputs();

    // Reset with a load presented: no request and no stall during reset.
    rst = 1'b1;
    mem_memRead = 1'b1;
    mem_regWriteData = 32'h100;
    mem_memSize = 2'b10;
    tick();
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_stall", 32'(mem_stall), 0);
    tick();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wb_en", 32'(wb_regWriteEn), 0);
    check("rst_wb_addr", 32'(wb_regWriteAddr), 0);
    check("rst_wb_data", wb_regWriteData, 0);
    check("rst_misalign", 32'(mem_misalign), 0);
    check("rst_buserr", 32'(mem_buserr), 0);
    tick();

    vecs.push_back(mkv(mk(1, 32'hDEAD, 0, 0, 2'd2, 0, 0, 0), 0, 0, 1, 1, 32'hDEAD));
    vecs.push_back(mkv(mk(1, 32'h100, 1, 0, 2'd2, 0, 0, 0), 1, 32'h12345678, 1, 1, 32'h12345678));
    vecs.push_back(mkv(mk(1, 32'h103, 1, 0, 2'd0, 1, 0, 1), 1, 32'h80FFFFFF, 1, 1, 32'hFFFFFF80));
    vecs.push_back(mkv(mk(1, 32'h103, 1, 0, 2'd0, 0, 0, 0), 0, 0, 1, 1, 32'h00000080));
    vecs.push_back(mkv(mk(1, 32'h102, 1, 0, 2'd1, 1, 0, 2), 0, 0, 1, 1, 32'hFFFF80FF));
    vecs.push_back(mkv(mk(1, 32'h102, 1, 0, 2'd1, 0, 0, 0), 0, 0, 1, 1, 32'h000080FF));
    vecs.push_back(mkv(mk(0, 32'h102, 0, 1, 2'd1, 0, 32'h0000BEEF, 1), 0, 0, 0, 1, 32'h102));
    vecs.push_back(mkv(mk(1, 32'h100, 1, 0, 2'd2, 0, 0, 0), 0, 0, 1, 1, 32'hBEEFFFFF));
    vecs.push_back(mkv(mk(0, 32'h101, 0, 1, 2'd0, 0, 32'h123456A5, 3), 0, 0, 0, 1, 32'h101));
    vecs.push_back(mkv(mk(1, 32'h101, 1, 0, 2'd0, 0, 0, 0), 0, 0, 1, 1, 32'h000000A5));
    vecs.push_back(mkv(mk(1, 32'h101, 1, 0, 2'd2, 0, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mkv(mk(1, 32'h103, 1, 0, 2'd1, 1, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mkv(mk(0, 32'h106, 0, 1, 2'd2, 0, 32'h55, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mkv(mk(1, 32'h104, 1, 0, 2'd2, 0, 0, 3), 1, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D));
    vecs.push_back(mkv(mk(1, 32'h108, 1, 0, 2'd2, 0, 0, 99), 0, 0, 0, 0, 0));
    vecs.push_back(mkv(mk(0, 32'h108, 0, 1, 2'd3, 0, 32'h01020304, 0), 0, 0, 0, 1, 32'h108));
    vecs.push_back(mkv(mk(1, 32'h10A, 1, 0, 2'd1, 1, 0, 1), 0, 0, 1, 1, 32'h00000102));
    vecs.push_back(mkv(mk(1, 32'h10B, 1, 0, 2'd0, 1, 0, 0), 0, 0, 1, 1, 32'h00000001));

    foreach (vecs[i]) begin
      if (vecs[i].preload) mem_model[int'(vecs[i].op.addr >> 2)] = vecs[i].pre_word;
      applyStimulus(vecs[i].op);
      checkOutput(i, vecs[i]);
    end

    // Reset while a request is outstanding: request gone next cycle, no writeback, no pulse.
    applyStimulus(mk(1, 32'h44, 0, 0, 2'd0, 0, 0, 0));
    mem_regWriteEn = 1'b1;
    mem_regWriteData = 32'h100;
    mem_memRead = 1'b1;
    mem_memSize = 2'd2;
    tick();
    @(negedge clk);
    check("midreq_req_before", 32'(dmem_req), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("midreq_req_after", 32'(dmem_req), 0);
    check("midreq_stall_after", 32'(mem_stall), 0);
    check("midreq_wb_en", 32'(wb_regWriteEn), 0);
    tick();
    check("midreq_buserr", 32'(mem_buserr), 0);
    check("midreq_misalign", 32'(mem_misalign), 0);
    check("midreq_wb_en_late", 32'(wb_regWriteEn), 0);

    for (int k = 0; k < 16; k++) mem_model[k] = $urandom;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      rop = mk(1'($urandom_range(0, 1)), $urandom, 0, 0, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
      rop.waddr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rop.ack_delay = 99;
      if (kind != 0) begin
        if ($urandom_range(0, 3) == 0) off = $urandom_range(0, 3);
        else if (rop.size == 2'd0) off = $urandom_range(0, 3);
        else if (rop.size == 2'd1) off = 2 * $urandom_range(0, 1);
        else off = 0;
        rop.addr = 32'($urandom_range(0, 15) * 4 + off);
        rop.rd = (kind == 1);
        rop.wr = (kind == 2);
        rop.we_en = (kind == 1);
      end
      applyStimulus(rop);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
